ulaplus_regs: RTL and testbench
===============================

Name: ulaplus_regs

Overview:
- ULAplus register and palette-access stage between the CPU bus decode and the SRAM memory controller.
- Decodes the ULAplus ports 0xBF3B (register select) and 0xFF3B (data), and holds the mode enable bit `up_en`.
- Turns palette writes and palette reads into single-beat requests to the memory controller, which stores the 64-entry palette in SRAM. The screen controller consumes `up_en`.

Parameters:
- ACK_TIMEOUT, 24, clk28 cycles a memory request may wait for `mem_ack` before it is abandoned.
- PORT_SEL, 16'hBF3B, register-select port address.
- PORT_DATA, 16'hFF3B, data port address.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst  in  1  reset, synchronous, active-high
- en  in  1  block enable; 0 = ports not decoded, no requests issued
- a  in  16  CPU address
- d_in  in  8  CPU data
- ioreq  in  1  qualified I/O request (M1 high, IORQ stable, address valid)
- rd  in  1  CPU read strobe, active-high
- wr  in  1  CPU write strobe, active-high
- d_out  out  8  read-back data
- d_out_active  out  1  `d_out` drives the CPU data bus
- up_en  out  1  ULAplus palette mode enabled
- mem_wr_req  out  1  palette write request
- mem_rd_req  out  1  palette read request
- mem_addr  out  6  palette entry index
- mem_wdata  out  8  palette write data
- mem_ack  in  1  one-cycle pulse: memory controller completed the request
- mem_rdata  in  8  SRAM data, valid in the `mem_ack` cycle of a read
- timeout_err  out  1  sticky flag: a request was abandoned

Behaviour:
- Reset values: sel_reg=0, `up_en`=0, `mem_wr_req`=0, `mem_rd_req`=0, `mem_addr`=0, `mem_wdata`=0, `d_out`=0, `d_out_active`=0, `timeout_err`=0, state IDLE, timeout counter 0.
- Reset mid-operation drops any request on the next clock edge. No `mem_ack` is required afterwards.
- Strobe detection:
  - `wr_stb` = `en` & `ioreq` & `wr` & `a`==port, registered rising-edge detect. It fires exactly one cycle per I/O write, however long `wr` is held.
  - `rd_stb` is the same construction using `rd`.
- Register select:
  - A write to PORT_SEL loads `d_in` into sel_reg.
  - Group = sel_reg[7:6]; index = sel_reg[5:0].
- Data-port write, decoded on group:
  - Group 00: `mem_addr`=index, `mem_wdata`=`d_in`, go to WR_PEND.
  - Group 01 with index 0: `up_en` <= `d_in`[0] in the cycle after `wr_stb`. No memory request.
  - Group 01 with other index, group 10, group 11: ignored.
- Data-port read, decoded on group:
  - Group 01 with index 0: `d_out`={7'b0,`up_en`}, with `d_out_active`=1 from the cycle after `rd_stb` while `rd` & `ioreq` remain.
  - Group 00: `mem_addr`=index, go to RD_PEND.
  - Anything else: `d_out_active` stays 0.
- Reads of PORT_SEL: `d_out_active` stays 0, since the port is write-only.
- FSM states:
  - IDLE: accept strobes as above.
  - WR_PEND: `mem_wr_req`=1. On `mem_ack` go to IDLE and drop `mem_wr_req` the same edge. A new group-00 `wr_stb` arriving in WR_PEND overwrites `mem_addr`/`mem_wdata` and restarts the timeout; the latest write wins and the request stays high.
  - RD_PEND: `mem_rd_req`=1. On `mem_ack` latch `mem_rdata` into `d_out`, set `d_out_active`=1, go to RD_HOLD.
  - RD_HOLD: keep driving until `rd`=0 or `ioreq`=0, then `d_out_active`=0 and go to IDLE.
- A `wr_stb` arriving in RD_PEND or RD_HOLD is ignored, since a Z80 cannot overlap I/O cycles.
- Timeout:
  - The counter runs in WR_PEND and RD_PEND.
  - When it reaches ACK_TIMEOUT, drop the request, set `timeout_err`, go to IDLE. In RD_PEND no data is driven.
  - `timeout_err` clears only on `rst`.
- `mem_ack` in IDLE or RD_HOLD is ignored.
- `en`=0: no strobes are decoded. Pending requests complete normally. `up_en` is forced to 0 in the next cycle and stays 0 while `en`=0.
- `mem_addr`/`mem_wdata` are stable for the whole time a request is high.
- Only one of `mem_wr_req` and `mem_rd_req` is ever high at a time.

Test Plan:
- Reset, then OUT BF3B,0x40; OUT FF3B,0x01 -> `up_en`=1 one cycle after the write strobe; no mem request. IN FF3B -> `d_out`=0x01, `d_out_active`=1.
- OUT BF3B,0x05; OUT FF3B,0xA7 with `wr` held 20 cycles, `mem_ack` returned 3 cycles after the request -> exactly one `mem_wr_req` pulse, `mem_addr`=5, `mem_wdata`=0xA7, request low on the cycle after the ack.
- OUT BF3B,0x05; IN FF3B; memory acks with `mem_rdata`=0x3C -> `d_out`=0x3C, `d_out_active` high until `rd` drops, then 0.
- Group-00 write issued and `mem_ack` never returned -> request drops after 24 cycles; `timeout_err`=1 and stays 1 until `rst`.
- Second OUT FF3B,0x11 (sel 0x06) while the first write is still pending -> `mem_addr`=6, `mem_wdata`=0x11, a single ack completes it.
- `rst` asserted during RD_PEND -> next cycle all outputs are at reset values; a late `mem_ack` has no effect. Separately, OUT BF3B,0x80; OUT FF3B,0xFF -> no request and `up_en` unchanged.

Source files
------------

// File: rtl/ulaplus_regs.sv
// ULAplus register/palette-access stage: decodes ports BF3B/FF3B, holds up_en,
// and turns palette accesses into single-beat SRAM requests with an ack timeout.
module ulaplus_regs #(
    parameter int          ACK_TIMEOUT = 24,
    parameter logic [15:0] PORT_SEL    = 16'hBF3B,
    parameter logic [15:0] PORT_DATA   = 16'hFF3B
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    input  logic        ioreq,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  d_out,
    output logic        d_out_active,
    output logic        up_en,
    output logic        mem_wr_req,
    output logic        mem_rd_req,
    output logic [5:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND, RD_HOLD} state_t;

    state_t        state;
    logic [7:0]    sel_reg;
    logic [CW-1:0] cnt;
    logic          wr_sel_q, wr_data_q, rd_data_q;

    logic wr_sel_c, wr_data_c, rd_data_c;
    logic wr_sel_stb, wr_data_stb, rd_data_stb;
    logic [1:0] grp;
    logic [5:0] idx;
    logic       is_palette, is_mode_reg;

    assign wr_sel_c  = en & ioreq & wr & (a == PORT_SEL);
    assign wr_data_c = en & ioreq & wr & (a == PORT_DATA);
    assign rd_data_c = en & ioreq & rd & (a == PORT_DATA);

    // One strobe per I/O cycle, no matter how long the CPU holds the strobe.
    assign wr_sel_stb  = wr_sel_c  & ~wr_sel_q;
    assign wr_data_stb = wr_data_c & ~wr_data_q;
    assign rd_data_stb = rd_data_c & ~rd_data_q;

    assign grp         = sel_reg[7:6];
    assign idx         = sel_reg[5:0];
    assign is_palette  = (grp == 2'b00);
    assign is_mode_reg = (grp == 2'b01) && (idx == 6'd0);

    // NOTE: all state uses non-blocking assignments and a synchronous reset, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state        <= IDLE;
            sel_reg      <= '0;
            cnt          <= '0;
            wr_sel_q     <= 1'b0;
            wr_data_q    <= 1'b0;
            rd_data_q    <= 1'b0;
            up_en        <= 1'b0;
            mem_wr_req   <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            d_out        <= '0;
            d_out_active <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wr_sel_q  <= wr_sel_c;
            wr_data_q <= wr_data_c;
            rd_data_q <= rd_data_c;

            if (wr_sel_stb)
                sel_reg <= d_in;

            // Strobes need en=1, so the later up_en writes never fight this.
            if (!en)
                up_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_data_stb) begin
                        if (is_palette) begin
                            mem_addr   <= idx;
                            mem_wdata  <= d_in;
                            mem_wr_req <= 1'b1;
                            cnt        <= '0;
                            state      <= WR_PEND;
                        end else if (is_mode_reg) begin
                            up_en <= d_in[0];
                        end
                    end else if (rd_data_stb) begin
                        if (is_palette) begin
                            mem_addr   <= idx;
                            mem_rd_req <= 1'b1;
                            cnt        <= '0;
                            state      <= RD_PEND;
                        end else if (is_mode_reg) begin
                            d_out        <= {7'b0, up_en};
                            d_out_active <= 1'b1;
                            state        <= RD_HOLD;
                        end
                    end
                end

                WR_PEND: begin
                    // A newer palette write replaces the pending one; the request stays up.
                    if (wr_data_stb && is_palette) begin
                        mem_addr  <= idx;
                        mem_wdata <= d_in;
                        cnt       <= '0;
                    end else if (mem_ack) begin
                        mem_wr_req <= 1'b0;
                        state      <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        mem_wr_req  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    if (wr_data_stb && is_mode_reg)
                        up_en <= d_in[0];
                end

                RD_PEND: begin
                    if (mem_ack) begin
                        d_out        <= mem_rdata;
                        d_out_active <= 1'b1;
                        mem_rd_req   <= 1'b0;
                        state        <= RD_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        mem_rd_req  <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RD_HOLD: begin
                    if (!(rd && ioreq)) begin
                        d_out_active <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ulaplus_regs.sv
// Directed bench for ulaplus_regs: mode register, palette write/read, write
// overwrite, ack timeout, reset during a read, ignored groups and en=0.
module tb_ulaplus_regs;

    logic        clk28 = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] a = '0;
    logic [7:0]  d_in = '0;
    logic        ioreq = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  d_out;
    logic        d_out_active;
    logic        up_en;
    logic        mem_wr_req;
    logic        mem_rd_req;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    ulaplus_regs dut (
        .clk28(clk28), .rst(rst), .en(en), .a(a), .d_in(d_in),
        .ioreq(ioreq), .rd(rd), .wr(wr),
        .d_out(d_out), .d_out_active(d_out_active), .up_en(up_en),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk28 = ~clk28;

    // Advance one clock and land 1 time unit after the edge for sampling/driving.
    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic io_out(input logic [15:0] addr, input logic [7:0] data);
        a = addr; d_in = data; ioreq = 1'b1; wr = 1'b1;
        tick();
        wr = 1'b0; ioreq = 1'b0;
        tick();
    endtask

    initial begin
        int hi;
        int rises;
        logic prev;

        // Reset
        tick(); tick();
        check("rst_up_en", 16'(up_en), 16'h0);
        check("rst_wr_req", 16'(mem_wr_req), 16'h0);
        check("rst_rd_req", 16'(mem_rd_req), 16'h0);
        check("rst_d_out", 16'(d_out), 16'h0);
        check("rst_d_out_active", 16'(d_out_active), 16'h0);
        check("rst_timeout_err", 16'(timeout_err), 16'h0);
        check("rst_mem_addr", 16'(mem_addr), 16'h0);
        check("rst_mem_wdata", 16'(mem_wdata), 16'h0);
        rst = 1'b0;
        tick();

        // Mode register write and read-back
        io_out(16'hBF3B, 8'h40);
        a = 16'hFF3B; d_in = 8'h01; ioreq = 1'b1; wr = 1'b1;
        tick();
        check("mode_up_en_next_cycle", 16'(up_en), 16'h1);
        check("mode_no_wr_req", 16'(mem_wr_req), 16'h0);
        wr = 1'b0; ioreq = 1'b0;
        tick();
        check("mode_no_req_after", 16'({mem_wr_req, mem_rd_req}), 16'h0);
        rd = 1'b1; ioreq = 1'b1;
        tick();
        check("mode_rd_active", 16'(d_out_active), 16'h1);
        check("mode_rd_data", 16'(d_out), 16'h01);
        check("mode_rd_no_mem", 16'(mem_rd_req), 16'h0);
        rd = 1'b0; ioreq = 1'b0;
        tick();
        check("mode_rd_release", 16'(d_out_active), 16'h0);

        // Palette write with wr held 20 cycles, ack 3 cycles after the request
        io_out(16'hBF3B, 8'h05);
        a = 16'hFF3B; d_in = 8'hA7; ioreq = 1'b1; wr = 1'b1;
        hi = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = (i == 3);
            tick();
            if (i == 0) begin
                check("pw_addr", 16'(mem_addr), 16'h05);
                check("pw_wdata", 16'(mem_wdata), 16'hA7);
            end
            if (i == 3)
                check("pw_req_low_after_ack", 16'(mem_wr_req), 16'h0);
            if (mem_wr_req) hi++;
            if (mem_wr_req && !prev) rises++;
            prev = mem_wr_req;
        end
        mem_ack = 1'b0;
        wr = 1'b0; ioreq = 1'b0;
        tick();
        check("pw_single_pulse", 16'(rises), 16'h1);
        check("pw_high_cycles", 16'(hi), 16'h3);

        // Palette read, data 0x3C
        rd = 1'b1; ioreq = 1'b1;
        tick();
        check("pr_rd_req", 16'(mem_rd_req), 16'h1);
        check("pr_addr", 16'(mem_addr), 16'h05);
        check("pr_not_active_yet", 16'(d_out_active), 16'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("pr_data", 16'(d_out), 16'h3C);
        check("pr_active", 16'(d_out_active), 16'h1);
        check("pr_req_dropped", 16'(mem_rd_req), 16'h0);
        tick();
        check("pr_active_hold", 16'(d_out_active), 16'h1);
        rd = 1'b0; ioreq = 1'b0;
        tick();
        check("pr_active_release", 16'(d_out_active), 16'h0);

        // Second write while the first is pending: latest wins, one ack completes
        io_out(16'hFF3B, 8'h22);
        check("ow_first_req", 16'(mem_wr_req), 16'h1);
        io_out(16'hBF3B, 8'h06);
        check("ow_still_pending", 16'(mem_wr_req), 16'h1);
        check("ow_addr_stable", 16'(mem_addr), 16'h05);
        a = 16'hFF3B; d_in = 8'h11; ioreq = 1'b1; wr = 1'b1;
        tick();
        check("ow_addr", 16'(mem_addr), 16'h06);
        check("ow_wdata", 16'(mem_wdata), 16'h11);
        wr = 1'b0; ioreq = 1'b0;
        tick();
        check("ow_req_high", 16'(mem_wr_req), 16'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ow_req_done", 16'(mem_wr_req), 16'h0);
        tick();
        check("ow_req_stays_low", 16'(mem_wr_req), 16'h0);
        check("ow_no_timeout", 16'(timeout_err), 16'h0);

        // Write never acked: request high for 24 cycles, then sticky error
        a = 16'hFF3B; d_in = 8'h99; ioreq = 1'b1; wr = 1'b1;
        tick();
        hi = 0;
        for (int g = 0; g < 40; g++) begin
            if (!mem_wr_req) break;
            hi++;
            wr = 1'b0; ioreq = 1'b0;
            tick();
        end
        check("to_req_cycles", 16'(hi), 16'd24);
        check("to_err_set", 16'(timeout_err), 16'h1);
        repeat (5) tick();
        check("to_err_sticky", 16'(timeout_err), 16'h1);
        check("to_no_req", 16'({mem_wr_req, mem_rd_req}), 16'h0);

        // Reset during RD_PEND, then a late ack
        a = 16'hFF3B; rd = 1'b1; ioreq = 1'b1;
        tick();
        check("rr_rd_req", 16'(mem_rd_req), 16'h1);
        check("rr_addr", 16'(mem_addr), 16'h06);
        rst = 1'b1; rd = 1'b0; ioreq = 1'b0;
        tick();
        check("rr_rd_req_dropped", 16'(mem_rd_req), 16'h0);
        check("rr_err_cleared", 16'(timeout_err), 16'h0);
        check("rr_addr_reset", 16'(mem_addr), 16'h0);
        check("rr_wdata_reset", 16'(mem_wdata), 16'h0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        tick();
        check("rr_late_ack_data", 16'(d_out), 16'h0);
        check("rr_late_ack_active", 16'(d_out_active), 16'h0);
        check("rr_late_ack_req", 16'({mem_wr_req, mem_rd_req}), 16'h0);

        // Group 10 write/read ignored; PORT_SEL is write-only
        io_out(16'hBF3B, 8'h40);
        io_out(16'hFF3B, 8'h01);
        check("g1_up_en_set", 16'(up_en), 16'h1);
        io_out(16'hBF3B, 8'h80);
        io_out(16'hFF3B, 8'hFF);
        check("g2_no_req", 16'({mem_wr_req, mem_rd_req}), 16'h0);
        check("g2_up_en_kept", 16'(up_en), 16'h1);
        a = 16'hFF3B; rd = 1'b1; ioreq = 1'b1;
        tick(); tick();
        check("g2_rd_not_driven", 16'({d_out_active, mem_rd_req}), 16'h0);
        rd = 1'b0; ioreq = 1'b0;
        tick();
        a = 16'hBF3B; rd = 1'b1; ioreq = 1'b1;
        tick(); tick();
        check("sel_rd_not_driven", 16'(d_out_active), 16'h0);
        rd = 1'b0; ioreq = 1'b0;
        tick();

        // en=0 forces up_en low and blocks decoding (sel_reg must stay 0x80)
        en = 1'b0;
        tick();
        check("en0_up_en_low", 16'(up_en), 16'h0);
        io_out(16'hBF3B, 8'h40);
        io_out(16'hFF3B, 8'h01);
        check("en0_up_en_stays", 16'(up_en), 16'h0);
        check("en0_no_req", 16'({mem_wr_req, mem_rd_req}), 16'h0);
        en = 1'b1;
        tick();
        io_out(16'hFF3B, 8'h01);
        check("en1_sel_not_loaded", 16'(up_en), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
